// File: rtl/vdot_feeder.sv
// vdot_feeder: operand sequencer for the serial half-precision dot unit.
// Latches two 16 x 16-bit vectors on request, streams one element pair per
// cycle while holding the dot unit's start, then waits for its done and
// returns the captured result with a one-cycle valid pulse.
// Optional feature macro: VDOT_FEEDER_TIMEOUT_EN (bounded WAIT with Err).
module vdot_feeder #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Req,
    input  logic [255:0] VA,
    input  logic [255:0] VB,
    output logic         Ack,
    output logic         Busy,
    output logic [15:0]  ElemA,
    output logic [15:0]  ElemB,
    output logic         DotStart,
    input  logic [15:0]  DotOut,
    input  logic         DotV,
    input  logic         DotDone,
    output logic [15:0]  Result,
    output logic         Overflow,
    output logic         Err,
    output logic         ResultValid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // A zero timeout would complete WAIT before the dot unit could answer.
    generate
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("vdot_feeder: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    // Pick element idx out of a packed 16-element vector.
    function automatic logic [15:0] f_elem(input logic [255:0] vec, input logic [3:0] idx);
        return vec[{idx, 4'd0} +: 16];
    endfunction

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [255:0]  r_va;
    logic [255:0]  r_vb;
    logic          r_ack;
    logic          r_busy;
    logic          r_start;
    logic [15:0]   r_elem_a;
    logic [15:0]   r_elem_b;
    logic [15:0]   r_result;
    logic          r_ovf;
    logic          r_err;
    logic          r_rv;

    state_t        w_state;
    logic [3:0]    w_idx;
    logic [255:0]  w_va;
    logic [255:0]  w_vb;
    logic          w_ack;
    logic          w_busy;
    logic          w_start;
    logic [15:0]   w_elem_a;
    logic [15:0]   w_elem_b;
    logic [15:0]   w_result;
    logic          w_ovf;
    logic          w_err;
    logic          w_rv;

`ifdef VDOT_FEEDER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt;
`endif

    // Next-state and next-output logic; every output is a register loaded here.
    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_va     = r_va;
        w_vb     = r_vb;
        w_ack    = 1'b0;
        w_busy   = r_busy;
        w_start  = r_start;
        w_elem_a = 16'h0000;
        w_elem_b = 16'h0000;
        w_result = r_result;
        w_ovf    = r_ovf;
        w_err    = r_err;
        w_rv     = 1'b0;
`ifdef VDOT_FEEDER_TIMEOUT_EN
        w_wcnt   = r_wcnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_busy  = 1'b0;
                w_start = 1'b0;
                w_idx   = 4'd0;
                if (Req) begin
                    // Element 0 goes out in the Ack cycle itself.
                    w_state  = ST_FEED;
                    w_va     = VA;
                    w_vb     = VB;
                    w_ack    = 1'b1;
                    w_busy   = 1'b1;
                    w_start  = 1'b1;
                    w_ovf    = 1'b0;
                    w_err    = 1'b0;
                    w_elem_a = f_elem(VA, 4'd0);
                    w_elem_b = f_elem(VB, 4'd0);
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_FEED: begin
                // DotDone is deliberately ignored here.
                w_ovf   = r_ovf | DotV;
                w_busy  = 1'b1;
                w_start = 1'b1;
                if (r_idx == 4'd15) begin
                    // Zero elements keep the still-running dot unit adding 0.
                    w_state = ST_WAIT;
`ifdef VDOT_FEEDER_TIMEOUT_EN
                    w_wcnt  = '0;
`endif
                end else begin
                    w_idx    = r_idx + 4'd1;
                    w_elem_a = f_elem(r_va, w_idx);
                    w_elem_b = f_elem(r_vb, w_idx);
                end
            end
            ST_WAIT: begin
                w_ovf   = r_ovf | DotV;
                w_busy  = 1'b1;
                w_start = 1'b1;
                if (DotDone) begin
                    w_state  = ST_IDLE;
                    w_result = DotOut;
                    w_rv     = 1'b1;
                    w_busy   = 1'b0;
                    w_start  = 1'b0;
                    w_idx    = 4'd0;
                end else begin
`ifdef VDOT_FEEDER_TIMEOUT_EN
                    if (r_wcnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
                        // Forced completion; overflow keeps its sticky value.
                        w_state  = ST_IDLE;
                        w_result = 16'h0000;
                        w_err    = 1'b1;
                        w_rv     = 1'b1;
                        w_busy   = 1'b0;
                        w_start  = 1'b0;
                        w_idx    = 4'd0;
                    end else begin
                        w_wcnt = r_wcnt + WCNT_W'(1);
                    end
`else
                    w_state = ST_WAIT;
`endif
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
                w_start = 1'b0;
                w_idx   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= 4'd0;
            r_va     <= 256'd0;
            r_vb     <= 256'd0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_elem_a <= 16'h0000;
            r_elem_b <= 16'h0000;
            r_result <= 16'h0000;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_rv     <= 1'b0;
`ifdef VDOT_FEEDER_TIMEOUT_EN
            r_wcnt   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_va     <= w_va;
            r_vb     <= w_vb;
            r_ack    <= w_ack;
            r_busy   <= w_busy;
            r_start  <= w_start;
            r_elem_a <= w_elem_a;
            r_elem_b <= w_elem_b;
            r_result <= w_result;
            r_ovf    <= w_ovf;
            r_err    <= w_err;
            r_rv     <= w_rv;
`ifdef VDOT_FEEDER_TIMEOUT_EN
            r_wcnt   <= w_wcnt;
`endif
        end
    end

    assign Ack         = r_ack;
    assign Busy        = r_busy;
    assign DotStart    = r_start;
    assign ElemA       = r_elem_a;
    assign ElemB       = r_elem_b;
    assign Result      = r_result;
    assign Overflow    = r_ovf;
    assign ResultValid = r_rv;
`ifdef VDOT_FEEDER_TIMEOUT_EN
    assign Err         = r_err;
`else
    assign Err         = 1'b0;
`endif

endmodule

// File: tb/tb_vdot_feeder.sv
// Testbench for vdot_feeder with a behavioural half-precision dot unit.
module tb_vdot_feeder;
    localparam int TIMEOUT_CYC = 8;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Req;
    logic [255:0] VA, VB;
    logic         Ack, Busy, DotStart, Overflow, Err, ResultValid;
    logic [15:0]  ElemA, ElemB, Result;
    logic [15:0]  DotOut = 16'h0000;
    logic         DotV = 1'b0;
    logic         DotDone = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    // dot unit model controls (0 means "never")
    int  done_lat = 17;
    bit  done_en = 1'b1;
    int  spur_at = 0;
    int  force_v_at = 0;
    int  m_cnt = 0;
    real m_acc = 0.0;

    // per-cycle observations of the last operation (index = cycle after edge 0)
    logic        obs_ack   [0:63];
    logic        obs_busy  [0:63];
    logic        obs_start [0:63];
    logic        obs_rv    [0:63];
    logic [15:0] obs_ea    [0:63];
    logic [15:0] obs_eb    [0:63];
    logic [15:0] obs_res;
    logic        obs_ovf, obs_err;

    vdot_feeder #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .VA(VA), .VB(VB),
        .Ack(Ack), .Busy(Busy), .ElemA(ElemA), .ElemB(ElemB),
        .DotStart(DotStart), .DotOut(DotOut), .DotV(DotV), .DotDone(DotDone),
        .Result(Result), .Overflow(Overflow), .Err(Err), .ResultValid(ResultValid)
    );

    always #5 Clk = ~Clk;

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real v, sc;
        e  = int'(h[14:10]);
        v  = real'(h[9:0]) / 1024.0;
        if (e == 0) e = 1;
        else v = v + 1.0;
        sc = 1.0;
        if (e >= 15) for (int k = 15; k < e; k++) sc = sc * 2.0;
        else         for (int k = e; k < 15; k++) sc = sc / 2.0;
        v = v * sc;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        real  a;
        int   e, m;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a == 0.0) return 16'h0000;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e > 15)  return {s, 15'h7c00};
        if (e < -14) return {s, 15'h0000};
        m = $rtoi((a - 1.0) * 1024.0);
        return {s, 5'(e + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] exp_dot(input logic [255:0] va, input logic [255:0] vb);
        real acc = 0.0;
        for (int i = 0; i < 16; i++) acc = acc + h2r(va[16*i +: 16]) * h2r(vb[16*i +: 16]);
        return r2h(acc);
    endfunction

    function automatic bit exp_ovf(input logic [255:0] va, input logic [255:0] vb);
        real p;
        bit  o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p = h2r(va[16*i +: 16]) * h2r(vb[16*i +: 16]);
            if (p > 65504.0 || p < -65504.0) o = 1'b1;
        end
        return o;
    endfunction

    // small-magnitude values so every sum is exactly representable
    function automatic logic [255:0] rand_vec();
        logic [15:0]  tbl [0:5];
        logic [255:0] v;
        tbl = '{16'h0000, 16'h3c00, 16'h4000, 16'hbc00, 16'h3800, 16'hc000};
        for (int i = 0; i < 16; i++) v[16*i +: 16] = tbl[$urandom_range(0, 5)];
        return v;
    endfunction

    // behavioural dot unit: accumulates while start is high
    always @(negedge Clk) begin
        real p;
        if (DotStart === 1'b1) begin
            m_cnt   = m_cnt + 1;
            p       = h2r(ElemA) * h2r(ElemB);
            m_acc   = m_acc + p;
            DotV    = (p > 65504.0) || (p < -65504.0) || (m_cnt == force_v_at);
            DotOut  = r2h(m_acc);
            DotDone = (done_en && (m_cnt == done_lat + 1)) || (m_cnt == spur_at);
        end else begin
            m_cnt   = 0;
            m_acc   = 0.0;
            DotV    = 1'b0;
            DotDone = 1'b0;
            DotOut  = 16'h0000;
        end
    end

    // one operation: request (unless chained), record each cycle until ResultValid
    task automatic do_op(input logic [255:0] va, input logic [255:0] vb, input bit hold,
                         input bit chained, input int req_from, input int req_to, output int lat);
        int  c;
        bit  seen;
        if (!chained) begin
            @(negedge Clk);
            VA = va; VB = vb; Req = 1'b1;
        end
        @(posedge Clk);
        lat = 0; seen = 1'b0; c = 0;
        while (!seen && c < 60) begin
            c++;
            @(negedge Clk);
            obs_ack[c] = Ack; obs_busy[c] = Busy; obs_start[c] = DotStart;
            obs_rv[c] = ResultValid; obs_ea[c] = ElemA; obs_eb[c] = ElemB;
            if (ResultValid === 1'b1) begin
                seen = 1'b1; lat = c;
                obs_res = Result; obs_ovf = Overflow; obs_err = Err;
            end
            if (!hold) begin
                Req = (c >= req_from && c <= req_to);
                VA = rand_vec(); VB = rand_vec();
            end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Req = 1'b0; VA = '0; VB = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_total++;
        if ({Ack, Busy, DotStart, ResultValid, Overflow, Err} !== 6'b0) $display("FAIL reset_flags: got %b exp 000000", {Ack, Busy, DotStart, ResultValid, Overflow, Err});
        else n_pass++;
        n_total++;
        if ({ElemA, ElemB, Result} !== 48'h0) $display("FAIL reset_data: got %h exp 0", {ElemA, ElemB, Result});
        else n_pass++;
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        n_total++;
        if ({Ack, Busy, DotStart, ResultValid} !== 4'b0) $display("FAIL idle_flags: got %b exp 0000", {Ack, Busy, DotStart, ResultValid});
        else n_pass++;
    endtask

    task automatic test_ones();
        logic [255:0] va;
        int lat;
        va = {16{16'h3c00}};
        do_op(va, va, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (lat !== 19) $display("FAIL ones_latency: got %0d exp 19", lat); else n_pass++;
        n_total++;
        if (obs_ack[1] !== 1'b1 || obs_busy[1] !== 1'b1) $display("FAIL ones_ack: got ack=%b busy=%b exp 1 1", obs_ack[1], obs_busy[1]); else n_pass++;
        for (int c = 1; c <= 18; c++) begin
            n_total++;
            if (obs_ea[c] !== (c <= 16 ? 16'h3c00 : 16'h0000) || obs_eb[c] !== obs_ea[c] || obs_start[c] !== 1'b1 || obs_busy[c] !== 1'b1 || (c > 1 && obs_ack[c] !== 1'b0))
                $display("FAIL ones_stream c%0d: got a=%h b=%h st=%b busy=%b ack=%b", c, obs_ea[c], obs_eb[c], obs_start[c], obs_busy[c], obs_ack[c]);
            else n_pass++;
        end
        n_total++;
        if (obs_res !== 16'h4c00 || obs_ovf !== 1'b0 || obs_err !== 1'b0) $display("FAIL ones_result: got %h ovf=%b err=%b exp 4c00 0 0", obs_res, obs_ovf, obs_err); else n_pass++;
        n_total++;
        if (obs_busy[19] !== 1'b0 || obs_start[19] !== 1'b0 || obs_ack[19] !== 1'b0) $display("FAIL ones_rv_cycle: got busy=%b st=%b ack=%b exp 0 0 0", obs_busy[19], obs_start[19], obs_ack[19]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        do_op('0, '0, 1'b1, 1'b0, 0, 0, lat1);
        n_total++;
        if (lat1 !== 19 || obs_res !== 16'h0000 || obs_ovf !== 1'b0) $display("FAIL b2b_first: got lat=%0d res=%h ovf=%b exp 19 0000 0", lat1, obs_res, obs_ovf); else n_pass++;
        n_total++;
        if (obs_start[18] !== 1'b1 || obs_start[19] !== 1'b0) $display("FAIL b2b_gap_a: got st18=%b st19=%b exp 1 0", obs_start[18], obs_start[19]); else n_pass++;
        do_op('0, '0, 1'b0, 1'b1, 0, 0, lat2);
        n_total++;
        if (obs_ack[1] !== 1'b1 || obs_start[1] !== 1'b1 || obs_rv[1] !== 1'b0) $display("FAIL b2b_second_ack: got ack=%b st=%b rv=%b exp 1 1 0", obs_ack[1], obs_start[1], obs_rv[1]); else n_pass++;
        n_total++;
        if (lat2 !== 19 || obs_res !== 16'h0000) $display("FAIL b2b_second: got lat=%0d res=%h exp 19 0000", lat2, obs_res); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [255:0] va, vr;
        int lat;
        va = '0; va[16*3 +: 16] = 16'h7bff;
        do_op(va, va, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (lat !== 19 || obs_ovf !== 1'b1 || obs_res !== exp_dot(va, va)) $display("FAIL ovf_set: got lat=%0d ovf=%b res=%h exp 19 1 %h", lat, obs_ovf, obs_res, exp_dot(va, va)); else n_pass++;
        do_op('0, '0, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (obs_ovf !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", obs_ovf); else n_pass++;
        // overflow reported only in the capture cycle must still be caught
        vr = rand_vec();
        force_v_at = done_lat + 1;
        do_op(vr, vr, 1'b0, 1'b0, 0, 0, lat);
        force_v_at = 0;
        n_total++;
        if (obs_ovf !== 1'b1 || obs_res !== exp_dot(vr, vr)) $display("FAIL ovf_capture_cycle: got ovf=%b res=%h exp 1 %h", obs_ovf, obs_res, exp_dot(vr, vr)); else n_pass++;
    endtask

    task automatic test_random();
        logic [255:0] va, vb;
        int lat, bad;
        for (int k = 0; k < 6; k++) begin
            va = rand_vec(); vb = rand_vec();
            done_lat = $urandom_range(17, 22);
            do_op(va, vb, 1'b0, 1'b0, 0, 0, lat);
            bad = 0;
            for (int c = 1; c <= 16; c++)
                if (obs_ea[c] !== va[16*(c-1) +: 16] || obs_eb[c] !== vb[16*(c-1) +: 16]) bad++;
            n_total++;
            if (bad != 0) $display("FAIL rand_stream op%0d: got %0d bad element cycles exp 0", k, bad); else n_pass++;
            n_total++;
            if (lat !== done_lat + 2) $display("FAIL rand_latency op%0d: got %0d exp %0d", k, lat, done_lat + 2); else n_pass++;
            n_total++;
            if (obs_res !== exp_dot(va, vb) || obs_ovf !== exp_ovf(va, vb)) $display("FAIL rand_result op%0d: got %h ovf=%b exp %h ovf=%b", k, obs_res, obs_ovf, exp_dot(va, vb), exp_ovf(va, vb)); else n_pass++;
        end
        done_lat = 17;
    endtask

    task automatic test_busy_req_spur_done();
        logic [255:0] va, vb;
        int lat, acks;
        va = rand_vec(); vb = rand_vec();
        spur_at = 5;
        do_op(va, vb, 1'b0, 1'b0, 3, 12, lat);
        spur_at = 0;
        acks = 0;
        for (int c = 2; c <= lat; c++) if (obs_ack[c] === 1'b1) acks++;
        n_total++;
        if (acks !== 0) $display("FAIL busy_req_ack: got %0d extra acks exp 0", acks); else n_pass++;
        n_total++;
        if (lat !== 19 || obs_res !== exp_dot(va, vb)) $display("FAIL spur_done: got lat=%0d res=%h exp 19 %h", lat, obs_res, exp_dot(va, vb)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [255:0] va, vb;
        int lat, rvs;
        va = rand_vec(); vb = rand_vec();
        @(negedge Clk);
        VA = va; VB = vb; Req = 1'b1;
        @(posedge Clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            Req = 1'b0;
        end
        n_total++;
        if (ElemA !== va[16*7 +: 16]) $display("FAIL rst_mid_index7: got %h exp %h", ElemA, va[16*7 +: 16]); else n_pass++;
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        n_total++;
        if ({DotStart, Busy, ResultValid, ElemA} !== 19'h0) $display("FAIL rst_mid_outputs: got st=%b busy=%b rv=%b a=%h exp 0", DotStart, Busy, ResultValid, ElemA); else n_pass++;
        rvs = 0;
        repeat (25) begin
            @(negedge Clk);
            if (ResultValid === 1'b1 || DotStart === 1'b1) rvs++;
        end
        n_total++;
        if (rvs !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles exp 0", rvs); else n_pass++;
        va = rand_vec(); vb = rand_vec();
        do_op(va, vb, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (lat !== 19 || obs_res !== exp_dot(va, vb)) $display("FAIL rst_mid_recover: got lat=%0d res=%h exp 19 %h", lat, obs_res, exp_dot(va, vb)); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [255:0] va;
        int lat;
        va = '0; va[16*3 +: 16] = 16'h7bff; va[16*9 +: 16] = 16'h3c00;
        done_en = 1'b0;
        do_op(va, va, 1'b0, 1'b0, 0, 0, lat);
`ifdef VDOT_FEEDER_TIMEOUT_EN
        done_en = 1'b1;
        n_total++;
        if (lat !== 17 + TIMEOUT_CYC) $display("FAIL timeout_latency: got %0d exp %0d", lat, 17 + TIMEOUT_CYC); else n_pass++;
        n_total++;
        if (obs_err !== 1'b1 || obs_res !== 16'h0000 || obs_ovf !== 1'b1) $display("FAIL timeout_result: got err=%b res=%h ovf=%b exp 1 0000 1", obs_err, obs_res, obs_ovf); else n_pass++;
        do_op('0, '0, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (lat !== 19 || obs_err !== 1'b0 || obs_ovf !== 1'b0) $display("FAIL timeout_clear: got lat=%0d err=%b ovf=%b exp 19 0 0", lat, obs_err, obs_ovf); else n_pass++;
`else
        n_total++;
        if (lat !== 0 || Busy !== 1'b1 || DotStart !== 1'b1 || Err !== 1'b0) $display("FAIL no_timeout_wait: got lat=%0d busy=%b st=%b err=%b exp 0 1 1 0", lat, Busy, DotStart, Err); else n_pass++;
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        done_en = 1'b1;
        do_op(va, va, 1'b0, 1'b0, 0, 0, lat);
        n_total++;
        if (lat !== 19 || obs_ovf !== 1'b1 || obs_err !== 1'b0) $display("FAIL no_timeout_recover: got lat=%0d ovf=%b err=%b exp 19 1 0", lat, obs_ovf, obs_err); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_ones();
        test_back_to_back();
        test_overflow();
        test_random();
        test_busy_req_spur_done();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
